// File: rtl/deserializer.sv
// Serial-to-parallel deserializer. Reassembles an MSB-first bit stream into
// left-aligned words, closing a word after DATA_W bits or on the first idle
// cycle once at least MIN_LEN bits have arrived. Shorter bursts are dropped
// and reported with a one-cycle runt pulse.
module deserializer #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MOD_W   = $clog2(DATA_W),
  parameter int unsigned MIN_LEN = 3
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              ser_data_i,
  input  logic              ser_data_val_i,
  output logic [DATA_W-1:0] deser_data_o,
  output logic [MOD_W-1:0]  deser_data_mod_o,
  output logic              deser_data_val_o,
  output logic              runt_o
);

  typedef enum logic [0:0] {StIdle, StCollect} state_e;

  localparam logic [MOD_W:0]   CntFull = (MOD_W+1)'(DATA_W);
  localparam logic [MOD_W:0]   CntMin  = (MOD_W+1)'(MIN_LEN);
  localparam logic [MOD_W-1:0] TopIdx  = MOD_W'(DATA_W - 1);

  state_e              state_q, state_d;
  logic [MOD_W:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]   sreg_q, sreg_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [MOD_W-1:0]    mod_q, mod_d;
  logic                val_q, val_d;
  logic                runt_q, runt_d;

  logic [MOD_W:0]      cnt_inc;
  logic [MOD_W-1:0]    bit_idx;

  // cnt_q never exceeds DATA_W-1 while collecting, so the index fits MOD_W bits.
  assign cnt_inc = cnt_q + 1'b1;
  assign bit_idx = TopIdx - cnt_q[MOD_W-1:0];

  // Next-state: shift in bits, close words on full count or first idle cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    data_d  = data_q;
    mod_d   = mod_q;
    val_d   = 1'b0;
    runt_d  = 1'b0;

    if (ser_data_val_i) begin
      sreg_d[bit_idx] = ser_data_i;
      if (cnt_inc == CntFull) begin
        // Full word: emit including the bit just received, restart at zero.
        data_d  = sreg_d;
        mod_d   = '0;
        val_d   = 1'b1;
        cnt_d   = '0;
        sreg_d  = '0;
        state_d = StIdle;
      end else begin
        cnt_d   = cnt_inc;
        state_d = StCollect;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          // Nothing collected; an idle cycle has no effect.
        end
        StCollect: begin
          if (cnt_q >= CntMin) begin
            data_d = sreg_q;
            mod_d  = cnt_q[MOD_W-1:0];
            val_d  = 1'b1;
          end else begin
            runt_d = 1'b1;
          end
          cnt_d   = '0;
          sreg_d  = '0;
          state_d = StIdle;
        end
        default: begin
          cnt_d   = '0;
          sreg_d  = '0;
          state_d = StIdle;
        end
      endcase
    end
  end

  // State register with synchronous reset; a reset discards any partial word.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sreg_q  <= '0;
      data_q  <= '0;
      mod_q   <= '0;
      val_q   <= 1'b0;
      runt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      data_q  <= data_d;
      mod_q   <= mod_d;
      val_q   <= val_d;
      runt_q  <= runt_d;
    end
  end

  assign deser_data_o     = data_q;
  assign deser_data_mod_o = mod_q;
  assign deser_data_val_o = val_q;
  assign runt_o           = runt_q;

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for the deserializer: full words, short words, runts,
// back-to-back streaming and reset mid-word.
module tb_deserializer;

  logic        clk;
  logic        srst;
  logic        ser_data;
  logic        ser_val;
  logic [15:0] deser_data;
  logic [3:0]  deser_mod;
  logic        deser_val;
  logic        runt;

  int total = 0;
  int bad   = 0;

  int val_seen  = 0;
  int runt_seen = 0;
  int both_seen = 0;

  int val_base;
  int runt_base;

  deserializer #(
    .DATA_W (16),
    .MOD_W  (4),
    .MIN_LEN(3)
  ) dut (
    .clk_i           (clk),
    .srst_i          (srst),
    .ser_data_i      (ser_data),
    .ser_data_val_i  (ser_val),
    .deser_data_o    (deser_data),
    .deser_data_mod_o(deser_mod),
    .deser_data_val_o(deser_val),
    .runt_o          (runt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count pulses mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (deser_val) val_seen++;
    if (runt) runt_seen++;
    if (deser_val && runt) both_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    ser_val  = 1'b1;
    ser_data = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(w[15-i]);
  endtask

  task automatic idle(input int n);
    ser_val  = 1'b0;
    ser_data = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    srst     = 1'b1;
    ser_val  = 1'b0;
    ser_data = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_data", 32'(deser_data), 32'h0);
    chk("reset_mod", 32'(deser_mod), 32'h0);
    chk("reset_val", 32'(deser_val), 32'h0);
    chk("reset_runt", 32'(runt), 32'h0);
    srst = 1'b0;
    idle(2);

    // Full word 0xA5C3, pulse one cycle after the last bit.
    val_base = val_seen;
    send_bits(16'hA5C3, 15);
    chk("full_no_early_val", 32'(deser_val), 32'h0);
    send_bit(1'b1);
    chk("full_val", 32'(deser_val), 32'h1);
    chk("full_data", 32'(deser_data), 32'hA5C3);
    chk("full_mod", 32'(deser_mod), 32'h0);
    chk("full_runt", 32'(runt), 32'h0);
    idle(3);
    chk("full_val_drop", 32'(deser_val), 32'h0);
    chk("full_one_pulse", 32'(val_seen - val_base), 32'h1);

    // Short word 1,0,1,1,0 closed by a gap.
    send_bits(16'b10110_00000000000, 5);
    chk("short5_pending", 32'(deser_val), 32'h0);
    idle(1);
    chk("short5_val", 32'(deser_val), 32'h1);
    chk("short5_data", 32'(deser_data), 32'hB000);
    chk("short5_mod", 32'(deser_mod), 32'h5);
    idle(1);
    chk("short5_val_drop", 32'(deser_val), 32'h0);
    chk("short5_hold_data", 32'(deser_data), 32'hB000);

    // Minimum length word, then a runt.
    send_bits(16'hE000, 3);
    idle(1);
    chk("min3_val", 32'(deser_val), 32'h1);
    chk("min3_data", 32'(deser_data), 32'hE000);
    chk("min3_mod", 32'(deser_mod), 32'h3);
    send_bits(16'hC000, 2);
    idle(1);
    chk("runt2_runt", 32'(runt), 32'h1);
    chk("runt2_val", 32'(deser_val), 32'h0);
    chk("runt2_data", 32'(deser_data), 32'hE000);
    chk("runt2_mod", 32'(deser_mod), 32'h3);
    idle(1);
    chk("runt2_drop", 32'(runt), 32'h0);

    // Single-bit runt.
    runt_base = runt_seen;
    send_bit(1'b1);
    idle(2);
    chk("runt1_count", 32'(runt_seen - runt_base), 32'h1);

    // Back-to-back full words, pulses exactly 16 cycles apart.
    val_base = val_seen;
    send_bits(16'h1234, 16);
    chk("b2b_first_val", 32'(deser_val), 32'h1);
    chk("b2b_first_data", 32'(deser_data), 32'h1234);
    chk("b2b_first_mod", 32'(deser_mod), 32'h0);
    send_bits(16'hFFFF, 15);
    chk("b2b_mid_val", 32'(deser_val), 32'h0);
    chk("b2b_mid_count", 32'(val_seen - val_base), 32'h1);
    send_bit(1'b1);
    chk("b2b_second_val", 32'(deser_val), 32'h1);
    chk("b2b_second_data", 32'(deser_data), 32'hFFFF);
    chk("b2b_second_mod", 32'(deser_mod), 32'h0);
    idle(2);
    chk("b2b_pulses", 32'(val_seen - val_base), 32'h2);

    // 15-bit word closed by a gap: largest short word.
    send_bits(16'hFFFF, 15);
    idle(1);
    chk("len15_val", 32'(deser_val), 32'h1);
    chk("len15_data", 32'(deser_data), 32'hFFFE);
    chk("len15_mod", 32'(deser_mod), 32'hF);
    idle(1);

    // Reset mid-word drops the partial word silently.
    val_base  = val_seen;
    runt_base = runt_seen;
    send_bits(16'hAAAA, 8);
    ser_val = 1'b0;
    srst    = 1'b1;
    @(posedge clk);
    #1;
    srst = 1'b0;
    chk("srst_data", 32'(deser_data), 32'h0);
    chk("srst_mod", 32'(deser_mod), 32'h0);
    send_bits(16'h0F0F, 16);
    chk("srst_word_data", 32'(deser_data), 32'h0F0F);
    chk("srst_word_val", 32'(deser_val), 32'h1);
    idle(3);
    chk("srst_pulses", 32'(val_seen - val_base), 32'h1);
    chk("srst_no_runt", 32'(runt_seen - runt_base), 32'h0);

    chk("never_both", 32'(both_seen), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
